// File: rtl/hazard_control_mc.sv
// hazard_control_mc: pipeline hazard unit for the 5-stage core.
// Provides EX>MEM>WB operand forwarding into ID and branch flushing.
// Adds a 1- or 2-cycle load-use stall, a multi-cycle MDU freeze handshake
// and a saturating counter of stalled (stop_PC) cycles.

`ifndef DRAM_RD
`define DRAM_RD 2'b01
`endif

module hazard_control_mc #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic [1:0]        wd_sel_EX,
  input  logic [1:0]        wd_sel_MEM,
  input  logic              rD1_flag,
  input  logic              rD2_flag,
  input  logic              rf_we_EX,
  input  logic              rf_we_MEM,
  input  logic              rf_we_WB,
  input  logic [REG_AW-1:0] rR1_ID,
  input  logic [REG_AW-1:0] rR2_ID,
  input  logic [REG_AW-1:0] wR_EX,
  input  logic [REG_AW-1:0] wR_MEM,
  input  logic [REG_AW-1:0] wR_WB,
  input  logic [DATA_W-1:0] wD_EX,
  input  logic [DATA_W-1:0] wD_MEM,
  input  logic [DATA_W-1:0] wD_WB,
  input  logic              npc_op,
  input  logic              mdu_start,
  input  logic              mdu_done,
  output logic              stop_PC,
  output logic              stop_IF_ID,
  output logic              stop_ID_EX,
  output logic              flush_IF_ID,
  output logic              flush_ID_EX,
  output logic              flush_EX_MEM,
  output logic              rD1_sel,
  output logic              rD2_sel,
  output logic [DATA_W-1:0] rD1_forward,
  output logic [DATA_W-1:0] rD2_forward,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD_WAIT = 2'd1;
  localparam logic [1:0] MDU_WAIT  = 2'd2;

  // Extra load-stall cycles beyond the first one spent in IDLE.
  localparam logic [1:0] LD_INIT = 2'(LOAD_STALL - 1);

  logic [1:0] state, state_nxt;
  logic [1:0] ld_cnt, ld_cnt_nxt;

  logic hit_ex_1, hit_mem_1, hit_wb_1;
  logic hit_ex_2, hit_mem_2, hit_wb_2;
  logic mem_fwd_ok;
  logic load_use;

  // When DRAM data only arrives in WB, a load sitting in MEM has nothing to forward.
  assign mem_fwd_ok = !((LOAD_STALL == 2) && (wd_sel_MEM == `DRAM_RD));

  assign hit_ex_1  = (wR_EX  == rR1_ID) && (wR_EX  != '0) && rf_we_EX  && rD1_flag;
  assign hit_mem_1 = (wR_MEM == rR1_ID) && (wR_MEM != '0) && rf_we_MEM && rD1_flag && mem_fwd_ok;
  assign hit_wb_1  = (wR_WB  == rR1_ID) && (wR_WB  != '0) && rf_we_WB  && rD1_flag;
  assign hit_ex_2  = (wR_EX  == rR2_ID) && (wR_EX  != '0) && rf_we_EX  && rD2_flag;
  assign hit_mem_2 = (wR_MEM == rR2_ID) && (wR_MEM != '0) && rf_we_MEM && rD2_flag && mem_fwd_ok;
  assign hit_wb_2  = (wR_WB  == rR2_ID) && (wR_WB  != '0) && rf_we_WB  && rD2_flag;

  assign load_use = (wd_sel_EX == `DRAM_RD) && (hit_ex_1 || hit_ex_2);

  // Forwarding muxes: youngest producer wins, zero when nothing matches.
  always_comb begin
    rD1_sel     = hit_ex_1 || hit_mem_1 || hit_wb_1;
    rD2_sel     = hit_ex_2 || hit_mem_2 || hit_wb_2;
    rD1_forward = '0;
    rD2_forward = '0;
    if (hit_ex_1)       rD1_forward = wD_EX;
    else if (hit_mem_1) rD1_forward = wD_MEM;
    else if (hit_wb_1)  rD1_forward = wD_WB;
    if (hit_ex_2)       rD2_forward = wD_EX;
    else if (hit_mem_2) rD2_forward = wD_MEM;
    else if (hit_wb_2)  rD2_forward = wD_WB;
  end

  // Stall/flush decode and next-state logic; everything held quiet during reset.
  always_comb begin
    stop_PC      = 1'b0;
    stop_IF_ID   = 1'b0;
    stop_ID_EX   = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    flush_EX_MEM = 1'b0;
    state_nxt    = state;
    ld_cnt_nxt   = ld_cnt;
    if (!cpu_rst) begin
      case (state)
        IDLE: begin
          if (npc_op) begin
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
          end else if (mdu_start) begin
            if (!mdu_done) begin
              stop_PC      = 1'b1;
              stop_IF_ID   = 1'b1;
              stop_ID_EX   = 1'b1;
              flush_EX_MEM = 1'b1;
              state_nxt    = MDU_WAIT;
            end
          end else if (load_use) begin
            stop_PC     = 1'b1;
            stop_IF_ID  = 1'b1;
            flush_ID_EX = 1'b1;
            if (LOAD_STALL == 2) begin
              state_nxt  = LOAD_WAIT;
              ld_cnt_nxt = LD_INIT;
            end
          end
        end
        LOAD_WAIT: begin
          stop_PC     = 1'b1;
          stop_IF_ID  = 1'b1;
          flush_ID_EX = 1'b1;
          ld_cnt_nxt  = ld_cnt - 2'd1;
          if (ld_cnt_nxt == 2'd0) state_nxt = IDLE;
        end
        MDU_WAIT: begin
          if (mdu_done) begin
            state_nxt = IDLE;
          end else begin
            stop_PC      = 1'b1;
            stop_IF_ID   = 1'b1;
            stop_ID_EX   = 1'b1;
            flush_EX_MEM = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and load-wait counter registers.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state  <= IDLE;
      ld_cnt <= 2'd0;
    end else begin
      state  <= state_nxt;
      ld_cnt <= ld_cnt_nxt;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      stall_cycles <= '0;
    end else if (stop_PC && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_control_mc.sv
// tb_hazard_control_mc: directed checks of hazard_control_mc.
// Two instances share all inputs: u_dut1 (LOAD_STALL=1, 32-bit counter)
// and u_dut2 (LOAD_STALL=2, 2-bit counter to reach saturation quickly).

`ifndef DRAM_RD
`define DRAM_RD 2'b01
`endif

module tb_hazard_control_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wd_sel_EX, wd_sel_MEM;
  logic        rD1_flag, rD2_flag;
  logic        rf_we_EX, rf_we_MEM, rf_we_WB;
  logic [4:0]  rR1_ID, rR2_ID, wR_EX, wR_MEM, wR_WB;
  logic [31:0] wD_EX, wD_MEM, wD_WB;
  logic        npc_op, mdu_start, mdu_done;

  logic        stop_PC1, stop_IF_ID1, stop_ID_EX1, flush_IF_ID1, flush_ID_EX1, flush_EX_MEM1;
  logic        rD1_sel1, rD2_sel1;
  logic [31:0] rD1_fwd1, rD2_fwd1;
  logic [31:0] stall1;

  logic        stop_PC2, stop_IF_ID2, stop_ID_EX2, flush_IF_ID2, flush_ID_EX2, flush_EX_MEM2;
  logic        rD1_sel2, rD2_sel2;
  logic [31:0] rD1_fwd2, rD2_fwd2;
  logic [1:0]  stall2;

  logic [5:0]  ctl1, ctl2;

  int vectors = 0;
  int miscompares = 0;

  // Control bundle order: stop_PC, stop_IF_ID, stop_ID_EX, flush_IF_ID, flush_ID_EX, flush_EX_MEM
  assign ctl1 = {stop_PC1, stop_IF_ID1, stop_ID_EX1, flush_IF_ID1, flush_ID_EX1, flush_EX_MEM1};
  assign ctl2 = {stop_PC2, stop_IF_ID2, stop_ID_EX2, flush_IF_ID2, flush_ID_EX2, flush_EX_MEM2};

  localparam logic [5:0] CTL_NONE   = 6'b000000;
  localparam logic [5:0] CTL_LOAD   = 6'b110010;
  localparam logic [5:0] CTL_BRANCH = 6'b000110;
  localparam logic [5:0] CTL_MDU    = 6'b111001;

  always #5 clk = ~clk;

  hazard_control_mc #(.DATA_W(32), .REG_AW(5), .LOAD_STALL(1), .CNT_W(32)) u_dut1 (
    .cpu_clk(clk), .cpu_rst(rst),
    .wd_sel_EX(wd_sel_EX), .wd_sel_MEM(wd_sel_MEM),
    .rD1_flag(rD1_flag), .rD2_flag(rD2_flag),
    .rf_we_EX(rf_we_EX), .rf_we_MEM(rf_we_MEM), .rf_we_WB(rf_we_WB),
    .rR1_ID(rR1_ID), .rR2_ID(rR2_ID),
    .wR_EX(wR_EX), .wR_MEM(wR_MEM), .wR_WB(wR_WB),
    .wD_EX(wD_EX), .wD_MEM(wD_MEM), .wD_WB(wD_WB),
    .npc_op(npc_op), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .stop_PC(stop_PC1), .stop_IF_ID(stop_IF_ID1), .stop_ID_EX(stop_ID_EX1),
    .flush_IF_ID(flush_IF_ID1), .flush_ID_EX(flush_ID_EX1), .flush_EX_MEM(flush_EX_MEM1),
    .rD1_sel(rD1_sel1), .rD2_sel(rD2_sel1),
    .rD1_forward(rD1_fwd1), .rD2_forward(rD2_fwd1),
    .stall_cycles(stall1)
  );

  hazard_control_mc #(.DATA_W(32), .REG_AW(5), .LOAD_STALL(2), .CNT_W(2)) u_dut2 (
    .cpu_clk(clk), .cpu_rst(rst),
    .wd_sel_EX(wd_sel_EX), .wd_sel_MEM(wd_sel_MEM),
    .rD1_flag(rD1_flag), .rD2_flag(rD2_flag),
    .rf_we_EX(rf_we_EX), .rf_we_MEM(rf_we_MEM), .rf_we_WB(rf_we_WB),
    .rR1_ID(rR1_ID), .rR2_ID(rR2_ID),
    .wR_EX(wR_EX), .wR_MEM(wR_MEM), .wR_WB(wR_WB),
    .wD_EX(wD_EX), .wD_MEM(wD_MEM), .wD_WB(wD_WB),
    .npc_op(npc_op), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .stop_PC(stop_PC2), .stop_IF_ID(stop_IF_ID2), .stop_ID_EX(stop_ID_EX2),
    .flush_IF_ID(flush_IF_ID2), .flush_ID_EX(flush_ID_EX2), .flush_EX_MEM(flush_EX_MEM2),
    .rD1_sel(rD1_sel2), .rD2_sel(rD2_sel2),
    .rD1_forward(rD1_fwd2), .rD2_forward(rD2_fwd2),
    .stall_cycles(stall2)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    wd_sel_EX = 2'b00; wd_sel_MEM = 2'b00;
    rD1_flag = 1'b0; rD2_flag = 1'b0;
    rf_we_EX = 1'b0; rf_we_MEM = 1'b0; rf_we_WB = 1'b0;
    rR1_ID = '0; rR2_ID = '0; wR_EX = '0; wR_MEM = '0; wR_WB = '0;
    wD_EX = '0; wD_MEM = '0; wD_WB = '0;
    npc_op = 1'b0; mdu_start = 1'b0; mdu_done = 1'b0;
  endtask

  // Advance n rising edges and leave 1 time unit after the last one.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
  endtask

  initial begin
    clearInputs();
    rst = 1'b1;
    #2;
    checkOutput("rst_ctl1", ctl1, CTL_NONE);
    checkOutput("rst_cnt1", stall1, 0);
    checkOutput("rst_cnt2", stall2, 0);
    applyStimulus(1);
    rst = 1'b0;

    $display("[TB] forwarding priority");
    wR_EX = 5'd5; rf_we_EX = 1'b1; wD_EX = 32'hAAAA;
    wR_MEM = 5'd5; rf_we_MEM = 1'b1; wD_MEM = 32'hBBBB;
    wR_WB = 5'd5; rf_we_WB = 1'b1; wD_WB = 32'hCCCC;
    rR1_ID = 5'd5; rD1_flag = 1'b1; rR2_ID = 5'd5; rD2_flag = 1'b0;
    #1;
    checkOutput("fwd_ex_sel", rD1_sel1, 1'b1);
    checkOutput("fwd_ex_data", rD1_fwd1, 32'hAAAA);
    checkOutput("fwd_ex_ctl", ctl1, CTL_NONE);
    checkOutput("fwd_noflag_sel", rD2_sel1, 1'b0);
    checkOutput("fwd_noflag_data", rD2_fwd1, 32'h0);
    rf_we_EX = 1'b0;
    #1;
    checkOutput("fwd_mem_data", rD1_fwd1, 32'hBBBB);
    checkOutput("fwd_mem_data2", rD1_fwd2, 32'hBBBB);
    wd_sel_MEM = `DRAM_RD;
    #1;
    checkOutput("fwd_memload_ls1", rD1_fwd1, 32'hBBBB);
    checkOutput("fwd_memload_ls2", rD1_fwd2, 32'hCCCC);
    wd_sel_MEM = 2'b00; rf_we_MEM = 1'b0;
    #1;
    checkOutput("fwd_wb_data", rD1_fwd1, 32'hCCCC);

    $display("[TB] register zero");
    clearInputs();
    wR_EX = 5'd0; rf_we_EX = 1'b1; wD_EX = 32'hDEAD; rR1_ID = 5'd0; rD1_flag = 1'b1;
    #1;
    checkOutput("x0_sel", rD1_sel1, 1'b0);
    checkOutput("x0_data", rD1_fwd1, 32'h0);
    clearInputs();
    applyStimulus(1);
    checkOutput("x0_cnt", stall1, 0);

    $display("[TB] load-use stall");
    wd_sel_EX = `DRAM_RD; rf_we_EX = 1'b1; wR_EX = 5'd7; wD_EX = 32'h9999;
    rR2_ID = 5'd7; rD2_flag = 1'b1;
    #1;
    checkOutput("ld_c0_ctl1", ctl1, CTL_LOAD);
    checkOutput("ld_c0_ctl2", ctl2, CTL_LOAD);
    applyStimulus(1);
    wd_sel_EX = 2'b00; rf_we_EX = 1'b0; wR_EX = 5'd0;
    wd_sel_MEM = `DRAM_RD; rf_we_MEM = 1'b1; wR_MEM = 5'd7; wD_MEM = 32'h1234;
    #1;
    checkOutput("ld_c1_ctl1", ctl1, CTL_NONE);
    checkOutput("ld_c1_sel1", rD2_sel1, 1'b1);
    checkOutput("ld_c1_fwd1", rD2_fwd1, 32'h1234);
    checkOutput("ld_c1_ctl2", ctl2, CTL_LOAD);
    checkOutput("ld_c1_sel2", rD2_sel2, 1'b0);
    checkOutput("ld_c1_cnt1", stall1, 1);
    checkOutput("ld_c1_cnt2", stall2, 1);
    applyStimulus(1);
    wd_sel_MEM = 2'b00; rf_we_MEM = 1'b0; wR_MEM = 5'd0;
    rf_we_WB = 1'b1; wR_WB = 5'd7; wD_WB = 32'h1234;
    #1;
    checkOutput("ld_c2_ctl2", ctl2, CTL_NONE);
    checkOutput("ld_c2_sel2", rD2_sel2, 1'b1);
    checkOutput("ld_c2_fwd2", rD2_fwd2, 32'h1234);
    checkOutput("ld_c2_cnt2", stall2, 2);
    checkOutput("ld_c2_cnt1", stall1, 1);

    $display("[TB] branch over load-use");
    clearInputs();
    wd_sel_EX = `DRAM_RD; rf_we_EX = 1'b1; wR_EX = 5'd9; rR1_ID = 5'd9; rD1_flag = 1'b1;
    npc_op = 1'b1;
    #1;
    checkOutput("br_ctl1", ctl1, CTL_BRANCH);
    checkOutput("br_ctl2", ctl2, CTL_BRANCH);
    applyStimulus(1);
    clearInputs();
    #1;
    checkOutput("br_after_ctl2", ctl2, CTL_NONE);
    checkOutput("br_cnt1", stall1, 1);
    checkOutput("br_cnt2", stall2, 2);

    $display("[TB] mdu freeze");
    doReset();
    mdu_start = 1'b1;
    #1;
    checkOutput("mdu_c0_ctl1", ctl1, CTL_MDU);
    for (int i = 1; i < 5; i++) begin
      applyStimulus(1);
      mdu_start = 1'b0;
      #1;
      checkOutput($sformatf("mdu_c%0d_ctl1", i), ctl1, CTL_MDU);
    end
    checkOutput("mdu_c4_ctl2", ctl2, CTL_MDU);
    applyStimulus(1);
    mdu_done = 1'b1;
    #1;
    checkOutput("mdu_done_ctl1", ctl1, CTL_NONE);
    checkOutput("mdu_done_cnt1", stall1, 5);
    checkOutput("mdu_sat_cnt2", stall2, 3);
    applyStimulus(1);
    mdu_done = 1'b0;
    #1;
    checkOutput("mdu_idle_ctl1", ctl1, CTL_NONE);
    mdu_start = 1'b1; mdu_done = 1'b1;
    #1;
    checkOutput("mdu_fast_ctl1", ctl1, CTL_NONE);
    applyStimulus(1);
    clearInputs();
    #1;
    checkOutput("mdu_fast_cnt1", stall1, 5);

    $display("[TB] mdu over load-use");
    wd_sel_EX = `DRAM_RD; rf_we_EX = 1'b1; wR_EX = 5'd3; rR1_ID = 5'd3; rD1_flag = 1'b1;
    mdu_start = 1'b1;
    #1;
    checkOutput("mdu_ld_ctl1", ctl1, CTL_MDU);
    checkOutput("mdu_ld_ctl2", ctl2, CTL_MDU);
    applyStimulus(1);
    clearInputs();
    mdu_done = 1'b1;
    #1;
    checkOutput("mdu_ld_done_ctl1", ctl1, CTL_NONE);
    checkOutput("mdu_ld_cnt1", stall1, 6);
    checkOutput("mdu_ld_cnt2", stall2, 3);
    applyStimulus(1);
    clearInputs();

    $display("[TB] reset during mdu wait");
    mdu_start = 1'b1;
    applyStimulus(1);
    mdu_start = 1'b0;
    #1;
    checkOutput("rstmdu_wait_ctl1", ctl1, CTL_MDU);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstmdu_ctl1", ctl1, CTL_NONE);
    checkOutput("rstmdu_ctl2", ctl2, CTL_NONE);
    checkOutput("rstmdu_cnt1", stall1, 0);
    checkOutput("rstmdu_cnt2", stall2, 0);
    mdu_start = 1'b1;
    #1;
    checkOutput("rstmdu_forced_ctl1", ctl1, CTL_NONE);
    applyStimulus(1);
    mdu_start = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("rstmdu_rel_ctl1", ctl1, CTL_NONE);
    applyStimulus(1);
    checkOutput("rstmdu_idle_ctl1", ctl1, CTL_NONE);
    checkOutput("rstmdu_idle_cnt1", stall1, 0);
    mdu_start = 1'b1;
    #1;
    checkOutput("rstmdu_restart_ctl1", ctl1, CTL_MDU);
    applyStimulus(1);
    clearInputs();
    mdu_done = 1'b1;
    #1;
    checkOutput("rstmdu_restart_done", ctl1, CTL_NONE);
    checkOutput("rstmdu_restart_cnt1", stall1, 1);
    applyStimulus(1);
    clearInputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
